// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and pixel colour type for the text raster path.
// Contents:
//   H_ACTIVE/H_FP/H_SYNC/H_BP, V_ACTIVE/V_FP/V_SYNC/V_BP : 640x480@60 timing
//   H_TOTAL/V_TOTAL                                      : derived line/frame lengths
//   CNT_W                                                : raster counter width
//   rgb12_t                                              : {r,g,b} 4-bit nibbles
//   dim_rgb()                                            : halves each colour channel
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W    = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Shift every channel right by one (FFF -> 777).
    function automatic rgb12_t dim_rgb(input rgb12_t c);
        rgb12_t d;
        d.r = c.r >> 1;
        d.g = c.g >> 1;
        d.b = c.b >> 1;
        return d;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters plus stage-0 decode.
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   hcnt, vcnt      : current raster position (10 bits each)
//   active0         : position is inside the visible area
//   hs0, vs0        : sync pulse windows (active-high)
//   sof0            : position is (0,0)
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned p_h_active = H_ACTIVE,
    parameter int unsigned p_h_fporch = H_FP,
    parameter int unsigned p_h_sync   = H_SYNC,
    parameter int unsigned p_h_bporch = H_BP,
    parameter int unsigned p_v_active = V_ACTIVE,
    parameter int unsigned p_v_fporch = V_FP,
    parameter int unsigned p_v_sync   = V_SYNC,
    parameter int unsigned p_v_bporch = V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active0,
    output logic             hs0,
    output logic             vs0,
    output logic             sof0
);

    localparam int unsigned HT       = p_h_active + p_h_fporch + p_h_sync + p_h_bporch;
    localparam int unsigned VT       = p_v_active + p_v_fporch + p_v_sync + p_v_bporch;
    localparam int unsigned HS_FIRST = p_h_active + p_h_fporch;
    localparam int unsigned HS_LAST  = HS_FIRST + p_h_sync - 1;
    localparam int unsigned VS_FIRST = p_v_active + p_v_fporch;
    localparam int unsigned VS_LAST  = VS_FIRST + p_v_sync - 1;

    // Counters are 10 bits wide; larger totals cannot be represented.
    if (HT > 1024) begin : g_bad_h_total
        $error("vga_sync_counter: H_TOTAL %0d exceeds 1024", HT);
    end
    if (VT > 1024) begin : g_bad_v_total
        $error("vga_sync_counter: V_TOTAL %0d exceeds 1024", VT);
    end

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    // Next raster position: h wraps every line, v advances on the h wrap.
    always_comb begin
        hcnt_d = hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (32'(hcnt_q) == HT - 1) begin
            hcnt_d = '0;
            if (32'(vcnt_q) == VT - 1) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt    = hcnt_q;
    assign vcnt    = vcnt_q;
    assign active0 = (32'(hcnt_q) < p_h_active) && (32'(vcnt_q) < p_v_active);
    assign hs0     = (32'(hcnt_q) >= HS_FIRST) && (32'(hcnt_q) <= HS_LAST);
    assign vs0     = (32'(vcnt_q) >= VS_FIRST) && (32'(vcnt_q) <= VS_LAST);
    assign sof0    = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_text_driver.sv
// VGA raster stage for an 8x8-tile character buffer.
// Drives the buffer read address from the raster counters, takes read_lit one
// cycle later, and emits registered RGB/sync/frame_start with 2-cycle latency.
// Optional macro VGA_TEXT_DRIVER_SCANLINE_EN halves the colours on the last
// pixel row of every tile.
// Ports:
//   clk, rst                         : pixel clock, synchronous active-high reset
//   read_hchar/vchar/hoffset/voffset : tile address to the buffer (combinational)
//   read_lit                         : buffer pixel, valid one cycle after address
//   hsync, vsync                     : active-low sync pulses
//   red, green, blue                 : 4-bit colour channels
//   frame_start                      : 1-cycle pulse as pixel (0,0) reaches the pins
module vga_text_driver
    import vga_timing_pkg::*;
#(
    parameter int unsigned p_h_active = H_ACTIVE,
    parameter int unsigned p_h_fporch = H_FP,
    parameter int unsigned p_h_sync   = H_SYNC,
    parameter int unsigned p_h_bporch = H_BP,
    parameter int unsigned p_v_active = V_ACTIVE,
    parameter int unsigned p_v_fporch = V_FP,
    parameter int unsigned p_v_sync   = V_SYNC,
    parameter int unsigned p_v_bporch = V_BP,
    parameter logic [11:0] p_fg_color = 12'hFFF,
    parameter logic [11:0] p_bg_color = 12'h000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] read_hchar,
    output logic [5:0] read_vchar,
    output logic [2:0] read_hoffset,
    output logic [2:0] read_voffset,
    input  logic       read_lit,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_start
);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             active0, hs0, vs0, sof0;

    vga_sync_counter #(
        .p_h_active (p_h_active),
        .p_h_fporch (p_h_fporch),
        .p_h_sync   (p_h_sync),
        .p_h_bporch (p_h_bporch),
        .p_v_active (p_v_active),
        .p_v_fporch (p_v_fporch),
        .p_v_sync   (p_v_sync),
        .p_v_bporch (p_v_bporch)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .active0 (active0),
        .hs0     (hs0),
        .vs0     (vs0),
        .sof0    (sof0)
    );

    // vcnt[9] never addresses a visible tile.
    logic unused_vcnt_msb;
    assign unused_vcnt_msb = vcnt[9];

    // Blanking drives an out-of-range tile so the buffer returns unlit.
    always_comb begin
        read_hchar   = 7'h7F;
        read_vchar   = 6'h3F;
        read_hoffset = 3'd0;
        read_voffset = 3'd0;
        if (active0) begin
            read_hchar   = hcnt[9:3];
            read_hoffset = hcnt[2:0];
            read_vchar   = vcnt[8:3];
            read_voffset = vcnt[2:0];
        end
    end

    // Stage 1: raster qualifiers aligned with the buffer's read_lit.
    logic active1_q, active1_d;
    logic hs1_q, hs1_d;
    logic vs1_q, vs1_d;
    logic sof1_q, sof1_d;

    always_comb begin
        active1_d = active0;
        hs1_d     = hs0;
        vs1_d     = vs0;
        sof1_d    = sof0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active1_q <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            sof1_q    <= 1'b0;
        end else begin
            active1_q <= active1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            sof1_q    <= sof1_d;
        end
    end

`ifdef VGA_TEXT_DRIVER_SCANLINE_EN
    // Last pixel row of the tile, carried alongside the other stage-1 flags.
    logic vlast1_q, vlast1_d;

    always_comb begin
        vlast1_d = (read_voffset == 3'b111);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vlast1_q <= 1'b0;
        end else begin
            vlast1_q <= vlast1_d;
        end
    end
`endif

    // Stage 2: pin registers.
    rgb12_t fg_c, bg_c;
    rgb12_t rgb_q, rgb_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d;

    always_comb begin
        fg_c = rgb12_t'(p_fg_color);
        bg_c = rgb12_t'(p_bg_color);
`ifdef VGA_TEXT_DRIVER_SCANLINE_EN
        if (vlast1_q) begin
            fg_c = dim_rgb(rgb12_t'(p_fg_color));
            bg_c = dim_rgb(rgb12_t'(p_bg_color));
        end
`endif
        rgb_d = '0;
        if (active1_q) begin
            rgb_d = read_lit ? fg_c : bg_c;
        end
        hsync_d       = ~hs1_q;
        vsync_d       = ~vs1_q;
        frame_start_d = sof1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_text_driver.sv
// Directed bench for vga_text_driver. A full-size instance covers line timing,
// address mapping, the lit-pixel path and mid-frame reset; a reduced-timing
// instance covers frame-level sync, frame_start period and vertical blanking.
module tb_vga_text_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full 640x480 instance.
    logic       rst = 1'b1;
    logic [6:0] read_hchar;
    logic [5:0] read_vchar;
    logic [2:0] read_hoffset, read_voffset;
    logic       read_lit = 1'b0;
    logic       hsync, vsync, frame_start;
    logic [3:0] red, green, blue;

    vga_text_driver dut (
        .clk          (clk),
        .rst          (rst),
        .read_hchar   (read_hchar),
        .read_vchar   (read_vchar),
        .read_hoffset (read_hoffset),
        .read_voffset (read_voffset),
        .read_lit     (read_lit),
        .hsync        (hsync),
        .vsync        (vsync),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .frame_start  (frame_start)
    );

    // Buffer model: only tile column 5, pixel column 0 is lit; 1-cycle latency.
    always @(posedge clk) read_lit <= (read_hchar == 7'd5) && (read_hoffset == 3'd0);

    // Reduced instance: 24 cycles/line (hsync 18..21), 31 lines/frame (vsync 26..27).
    logic       rst_s = 1'b1;
    logic [6:0] hchar_s;
    logic [5:0] vchar_s;
    logic [2:0] hoff_s, voff_s;
    logic       lit_s = 1'b1;
    logic       hsync_s, vsync_s, fs_s;
    logic [3:0] red_s, green_s, blue_s;

    vga_text_driver #(
        .p_h_active (16), .p_h_fporch (2), .p_h_sync (4), .p_h_bporch (2),
        .p_v_active (24), .p_v_fporch (2), .p_v_sync (2), .p_v_bporch (3)
    ) dut_s (
        .clk          (clk),
        .rst          (rst_s),
        .read_hchar   (hchar_s),
        .read_vchar   (vchar_s),
        .read_hoffset (hoff_s),
        .read_voffset (voff_s),
        .read_lit     (lit_s),
        .hsync        (hsync_s),
        .vsync        (vsync_s),
        .red          (red_s),
        .green        (green_s),
        .blue         (blue_s),
        .frame_start  (fs_s)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_low, vs_low, fs_cnt;
        int k, hc, vc;
        logic [11:0] exp_rgb;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'({red, green, blue}), 32'h000);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_hchar", 32'(read_hchar), 32'd0);
        chk("rst_vchar", 32'(read_vchar), 32'd0);

        // ---------------- two lines of the full instance ----------------
        rst    = 1'b0;
        hs_low = 0;
        vs_low = 0;
        for (int c = 0; c < 1602; c++) begin
            // Address reflects the counter of this very cycle.
            if (c == 639) begin
                chk("addr639_hchar", 32'(read_hchar), 32'd79);
                chk("addr639_hoff", 32'(read_hoffset), 32'd7);
                chk("addr639_vchar", 32'(read_vchar), 32'd0);
            end
            if (c == 640) begin
                chk("addr640_hchar", 32'(read_hchar), 32'h7F);
                chk("addr640_vchar", 32'(read_vchar), 32'h3F);
                chk("addr640_hoff", 32'(read_hoffset), 32'd0);
            end
            if (c == 700) begin
                chk("addr700_hchar", 32'(read_hchar), 32'h7F);
                chk("addr700_vchar", 32'(read_vchar), 32'h3F);
            end
            if (c == 813) begin
                chk("addr813_hchar", 32'(read_hchar), 32'd1);
                chk("addr813_hoff", 32'(read_hoffset), 32'd5);
                chk("addr813_voff", 32'(read_voffset), 32'd1);
            end
            // Pins reflect the counter of two cycles ago.
            if (c < 2) begin
                chk("line_rgb", 32'({red, green, blue}), 32'h000);
                chk("line_hsync", 32'(hsync), 32'd1);
                chk("line_fs", 32'(frame_start), 32'd0);
            end else begin
                k  = c - 2;
                hc = k % 800;
                vc = k / 800;
                exp_rgb = ((hc == 40) && (vc < 480)) ? 12'hFFF : 12'h000;
                chk("line_rgb", 32'({red, green, blue}), 32'(exp_rgb));
                chk("line_hsync", 32'(hsync), ((hc >= 656) && (hc <= 751)) ? 32'd0 : 32'd1);
                chk("line_fs", 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
            end
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            @(negedge clk);
        end
        chk("hsync_low_2lines", 32'(hs_low), 32'd192);
        chk("vsync_low_2lines", 32'(vs_low), 32'd0);

        // ---------------- mid-frame reset at (300,2) ----------------
        repeat (298) @(negedge clk);
        chk("pre_rst_hchar", 32'(read_hchar), 32'd37);
        chk("pre_rst_hoff", 32'(read_hoffset), 32'd4);
        chk("pre_rst_voff", 32'(read_voffset), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_hchar", 32'(read_hchar), 32'd0);
        chk("mrst_hoff", 32'(read_hoffset), 32'd0);
        chk("mrst_vchar", 32'(read_vchar), 32'd0);
        chk("mrst_hsync0", 32'(hsync), 32'd1);
        chk("mrst_vsync0", 32'(vsync), 32'd1);
        chk("mrst_rgb0", 32'({red, green, blue}), 32'h000);
        chk("mrst_fs0", 32'(frame_start), 32'd0);
        @(negedge clk);
        chk("mrst_hoff1", 32'(read_hoffset), 32'd1);
        chk("mrst_hsync1", 32'(hsync), 32'd1);
        chk("mrst_vsync1", 32'(vsync), 32'd1);
        chk("mrst_rgb1", 32'({red, green, blue}), 32'h000);
        chk("mrst_fs1", 32'(frame_start), 32'd0);
        @(negedge clk);
        chk("mrst_fs2", 32'(frame_start), 32'd1);
        chk("mrst_hsync2", 32'(hsync), 32'd1);
        @(negedge clk);
        chk("mrst_fs3", 32'(frame_start), 32'd0);

        // ---------------- reduced instance, two frames, read_lit held 1 ----------------
        chk("s_rst_hsync", 32'(hsync_s), 32'd1);
        chk("s_rst_vsync", 32'(vsync_s), 32'd1);
        chk("s_rst_rgb", 32'({red_s, green_s, blue_s}), 32'h000);
        rst_s  = 1'b0;
        hs_low = 0;
        vs_low = 0;
        fs_cnt = 0;
        for (int c = 0; c < 1490; c++) begin
            if (c == 567) begin
                chk("s_addr_hchar", 32'(hchar_s), 32'd1);
                chk("s_addr_hoff", 32'(hoff_s), 32'd7);
                chk("s_addr_vchar", 32'(vchar_s), 32'd2);
                chk("s_addr_voff", 32'(voff_s), 32'd7);
            end
            if (c == 568) begin
                chk("s_addr568_hchar", 32'(hchar_s), 32'h7F);
            end
            if (c == 610) begin
                chk("s_vblank_hchar", 32'(hchar_s), 32'h7F);
                chk("s_vblank_vchar", 32'(vchar_s), 32'h3F);
                chk("s_vblank_voff", 32'(voff_s), 32'd0);
            end
            if (c >= 2) begin
                k  = c - 2;
                hc = k % 24;
                vc = (k / 24) % 31;
                exp_rgb = 12'h000;
                if ((hc < 16) && (vc < 24)) begin
                    exp_rgb = 12'hFFF;
`ifdef VGA_TEXT_DRIVER_SCANLINE_EN
                    if ((vc % 8) == 7) exp_rgb = 12'h777;
`endif
                end
                chk("s_rgb", 32'({red_s, green_s, blue_s}), 32'(exp_rgb));
                chk("s_fs", 32'(fs_s), ((k % 744) == 0) ? 32'd1 : 32'd0);
            end
            if (!hsync_s) hs_low++;
            if (!vsync_s) vs_low++;
            if (fs_s) fs_cnt++;
            @(negedge clk);
        end
        chk("s_hsync_low", 32'(hs_low), 32'd248);
        chk("s_vsync_low", 32'(vs_low), 32'd96);
        chk("s_fs_count", 32'(fs_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
